// File: rtl/gshare_bp_pipe_if.sv
// Committed-update channel between the FTQ/execute side and the gshare predictor.
// The resolving stage is the master; the predictor accepts on valid & ready.
interface gshare_bp_pipe_if #(
  parameter int unsigned ROW_BITS  = 9,
  parameter int unsigned SLOT_BITS = 1
) ();
  logic                 valid;
  logic                 ready;
  logic [ROW_BITS-1:0]  index;
  logic [SLOT_BITS-1:0] slot;
  logic                 taken;

  modport master (output valid, index, slot, taken, input ready);
  modport slave  (input valid, index, slot, taken, output ready);
endinterface

// File: rtl/gshare_bp_pipe.sv
// Gshare direction predictor: speculative GHR XOR PC row index, flop table of
// saturating counters, 2-stage forwarded update pipeline and a row-per-cycle init sweep.
module gshare_bp_pipe #(
  parameter int unsigned VLEN            = 39,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned RVC             = 1,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned HIST_BITS       = 8,
  localparam int unsigned ROWS      = NR_ENTRIES / INSTR_PER_FETCH,
  localparam int unsigned ROW_BITS  = $clog2(ROWS),
  localparam int unsigned SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_bp_i,
  input  logic                       debug_mode_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       spec_valid_i,
  input  logic                       spec_taken_i,
  input  logic                       restore_valid_i,
  input  logic [HIST_BITS-1:0]       restore_ghr_i,
  input  logic                       restore_taken_i,
  gshare_bp_pipe_if.slave            upd,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [ROW_BITS-1:0]        index_o,
  output logic [HIST_BITS-1:0]       ghr_o,
  output logic                       busy_o
);

  localparam int unsigned OFFSET  = (RVC == 1) ? 1 : 2;
  localparam int unsigned IDX_LSB = SLOT_BITS + OFFSET;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic [ROW_BITS-1:0]  index;
    logic [SLOT_BITS-1:0] slot;
    logic                 taken;
  } upd_t;

  state_e               state_q, state_d;
  logic [ROW_BITS-1:0]  sweep_q, sweep_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  logic [INSTR_PER_FETCH-1:0]               valid_q [ROWS];
  logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0] ctr_q   [ROWS];

  logic                s1_valid_q, s2_valid_q;
  upd_t                s1_q, s2_q;
  logic [CTR_BITS-1:0] s2_ctr_q, s2_ctr_new, s1_ctr_rd;
  logic                accept;
  logic                unused_bits;

  // FSM next state and status outputs.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    busy_o    = 1'b0;
    upd.ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        busy_o = 1'b1;
        if (flush_bp_i) begin
          sweep_d = '0;
        end else if (sweep_q == LAST_ROW) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + ROW_BITS'(1);
        end
      end
      ST_RUN: begin
        upd.ready = 1'b1;
        if (flush_bp_i) begin
          state_d = ST_INIT;
          sweep_d = '0;
        end
      end
    endcase
  end

  // Restore carries the resolved direction on top of the checkpoint, so it beats a fresh guess.
  always_comb begin
    ghr_d = ghr_q;
    if (flush_bp_i)           ghr_d = '0;
    else if (restore_valid_i) ghr_d = {restore_ghr_i[HIST_BITS-2:0], restore_taken_i};
    else if (spec_valid_i)    ghr_d = {ghr_q[HIST_BITS-2:0], spec_taken_i};
  end

  assign accept = upd.valid & upd.ready & ~debug_mode_i;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      ghr_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      ghr_q      <= ghr_d;
      s1_valid_q <= accept & ~flush_bp_i;
      s2_valid_q <= s1_valid_q & ~flush_bp_i;
    end
  end

  // Back-to-back hits on one entry must see the counter S2 is about to write.
  assign s1_ctr_rd = (s2_valid_q && s2_q.index == s1_q.index && s2_q.slot == s1_q.slot)
                   ? s2_ctr_new : ctr_q[s1_q.index][s1_q.slot];

  always_ff @(posedge clk_i) begin
    s1_q     <= '{index: upd.index, slot: upd.slot, taken: upd.taken};
    s2_q     <= s1_q;
    s2_ctr_q <= s1_ctr_rd;
  end

  always_comb begin
    s2_ctr_new = s2_ctr_q;
    if (s2_q.taken) begin
      if (s2_ctr_q != CTR_MAX) s2_ctr_new = s2_ctr_q + CTR_BITS'(1);
    end else begin
      if (s2_ctr_q != '0)      s2_ctr_new = s2_ctr_q - CTR_BITS'(1);
    end
  end

  // NOTE: the table has no reset; the init sweep defines every entry before predictions are enabled.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      valid_q[sweep_q] <= '0;
      ctr_q[sweep_q]   <= {INSTR_PER_FETCH{CTR_INIT}};
    end else if (s2_valid_q) begin
      valid_q[s2_q.index][s2_q.slot] <= 1'b1;
      ctr_q[s2_q.index][s2_q.slot]   <= s2_ctr_new;
    end
  end

  assign index_o = vpc_i[IDX_LSB +: ROW_BITS] ^ ROW_BITS'(ghr_q);
  assign ghr_o   = ghr_q;

  for (genvar s = 0; s < INSTR_PER_FETCH; s++) begin : g_pred
    assign pred_valid_o[s] = (state_q == ST_RUN) & valid_q[index_o][s];
    assign pred_taken_o[s] = (state_q == ST_RUN) & ctr_q[index_o][s][CTR_BITS-1];
  end

  assign unused_bits = ^{vpc_i, restore_ghr_i};

endmodule

// File: tb/tb_gshare_bp_pipe.sv
// Scoreboard bench for gshare_bp_pipe: a default-sized instance plus a small CTR_BITS=3 instance.
// Expectations are queued with a due cycle when stimulus is driven and compared on the falling edge.
module tb_gshare_bp_pipe;

  localparam int unsigned ROW_BITS0 = 9;
  localparam int unsigned ROW_BITS1 = 5;

  typedef enum int {K_BUSY0, K_READY0, K_PV0, K_PT0, K_GHR0, K_IDX0, K_BUSY1, K_PV1, K_PT1} obs_e;

  typedef struct {
    string       tag;
    int          due;
    obs_e        kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;
  exp_t        sb_q[$];

  logic        flush0, debug0, spec_v0, spec_t0, rest_v0, rest_t0;
  logic [7:0]  rest_ghr0;
  logic [38:0] vpc0;
  logic [1:0]  pv0, pt0;
  logic [ROW_BITS0-1:0] idx0;
  logic [7:0]  ghr0;
  logic        busy0;

  logic [38:0] vpc1;
  logic [1:0]  pv1, pt1;
  logic [ROW_BITS1-1:0] idx1;
  logic [3:0]  ghr1;
  logic        busy1;

  gshare_bp_pipe_if #(.ROW_BITS(ROW_BITS0), .SLOT_BITS(1)) upd0_if ();
  gshare_bp_pipe_if #(.ROW_BITS(ROW_BITS1), .SLOT_BITS(1)) upd1_if ();

  gshare_bp_pipe dut0 (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(flush0), .debug_mode_i(debug0), .vpc_i(vpc0),
    .spec_valid_i(spec_v0), .spec_taken_i(spec_t0), .restore_valid_i(rest_v0),
    .restore_ghr_i(rest_ghr0), .restore_taken_i(rest_t0), .upd(upd0_if),
    .pred_valid_o(pv0), .pred_taken_o(pt0), .index_o(idx0), .ghr_o(ghr0), .busy_o(busy0)
  );

  gshare_bp_pipe #(.NR_ENTRIES(64), .CTR_BITS(3), .HIST_BITS(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_bp_i(1'b0), .debug_mode_i(1'b0), .vpc_i(vpc1),
    .spec_valid_i(1'b0), .spec_taken_i(1'b0), .restore_valid_i(1'b0),
    .restore_ghr_i(4'h0), .restore_taken_i(1'b0), .upd(upd1_if),
    .pred_valid_o(pv1), .pred_taken_o(pt1), .index_o(idx1), .ghr_o(ghr1), .busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(obs_e k);
    case (k)
      K_BUSY0:  return 32'(busy0);
      K_READY0: return 32'(upd0_if.ready);
      K_PV0:    return 32'(pv0);
      K_PT0:    return 32'(pt0);
      K_GHR0:   return 32'(ghr0);
      K_IDX0:   return 32'(idx0);
      K_BUSY1:  return 32'(busy1);
      K_PV1:    return 32'(pv1);
      K_PT1:    return 32'(pt1);
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic sb_push(input string tag, input obs_e kind, input logic [31:0] exp, input int delay);
    exp_t e;
    e.tag  = tag;
    e.due  = cyc + delay;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : sb_check
    int i;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].due == cyc) begin
        check(sb_q[i].tag, observe(sb_q[i].kind), sb_q[i].exp);
        sb_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic drive_upd0(input logic v, input logic [ROW_BITS0-1:0] idx, input logic slot, input logic tk);
    upd0_if.valid = v;
    upd0_if.index = idx;
    upd0_if.slot  = slot;
    upd0_if.taken = tk;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    flush0 = 1'b0; debug0 = 1'b0; spec_v0 = 1'b0; spec_t0 = 1'b0;
    rest_v0 = 1'b0; rest_t0 = 1'b0; rest_ghr0 = '0;
    vpc0 = 39'd20;  // row 5 with ghr 0
    vpc1 = 39'd12;  // row 3
    drive_upd0(1'b0, '0, 1'b0, 1'b0);
    upd1_if.valid = 1'b0; upd1_if.index = 5'd3; upd1_if.slot = 1'b0; upd1_if.taken = 1'b0;

    tick(); tick();
    sb_push("rst_busy",  K_BUSY0,  1, 0);
    sb_push("rst_ready", K_READY0, 0, 0);
    sb_push("rst_pv",    K_PV0,    0, 0);
    sb_push("rst_pt",    K_PT0,    0, 0);
    sb_push("rst_ghr",   K_GHR0,   0, 0);
    sb_push("rst_busy1", K_BUSY1,  1, 0);
    rst = 1'b0;
    sb_push("init_ready_mid", K_READY0, 0, 300);
    sb_push("init_pv_mid",    K_PV0,    0, 100);
    sb_push("init_pt_mid",    K_PT0,    0, 100);
    sb_push("init_busy_last", K_BUSY0,  1, 511);
    sb_push("init_done_busy", K_BUSY0,  0, 512);
    sb_push("init_done_rdy",  K_READY0, 1, 512);
    sb_push("init1_busy_last", K_BUSY1, 1, 31);
    sb_push("init1_done",      K_BUSY1, 0, 32);

    // CTR_BITS=3: five not-taken from 4 floor at 0, then four taken climb to 4.
    while (cyc < 40) tick();
    sb_push("c3_before", K_PT1, 2'b11, 2);
    sb_push("c3_pv_before", K_PV1, 2'b00, 2);
    for (int d = 3; d <= 8; d++) begin
      sb_push("c3_nt_pt", K_PT1, 2'b10, d);
      sb_push("c3_nt_pv", K_PV1, 2'b01, d);
    end
    for (int i = 0; i < 5; i++) begin
      upd1_if.valid = 1'b1; upd1_if.taken = 1'b0;
      tick();
    end
    upd1_if.valid = 1'b0;
    repeat (5) tick();
    for (int d = 3; d <= 5; d++) sb_push("c3_t_low", K_PT1, 2'b10, d);
    sb_push("c3_t_high", K_PT1, 2'b11, 6);
    sb_push("c3_t_hold", K_PT1, 2'b11, 8);
    for (int i = 0; i < 4; i++) begin
      upd1_if.valid = 1'b1; upd1_if.taken = 1'b1;
      tick();
    end
    upd1_if.valid = 1'b0;

    // Saturation at 3: four taken then one not-taken on row 5 slot 1.
    while (cyc < 520) tick();
    sb_push("fresh_idx", K_IDX0, 5, 0);
    sb_push("fresh_pv",  K_PV0,  2'b00, 0);
    sb_push("fresh_pt",  K_PT0,  2'b11, 0);
    sb_push("sat_pv_before", K_PV0, 2'b00, 2);
    for (int d = 3; d <= 8; d++) begin
      sb_push("sat_pv", K_PV0, 2'b10, d);
      sb_push("sat_pt", K_PT0, 2'b11, d);
    end
    for (int i = 0; i < 5; i++) begin
      drive_upd0(1'b1, 9'd5, 1'b1, i < 4);
      tick();
    end
    drive_upd0(1'b0, '0, 1'b0, 1'b0);
    repeat (6) tick();

    // Forwarding: NT, NT, T on a fresh 2-bit entry ends at 1, not 2.
    vpc0 = 39'd28;
    sb_push("fwd_idx", K_IDX0, 7, 0);
    sb_push("fwd_fresh_pt", K_PT0, 2'b11, 0);
    for (int d = 3; d <= 7; d++) begin
      sb_push("fwd_pt", K_PT0, 2'b10, d);
      sb_push("fwd_pv", K_PV0, 2'b01, d);
    end
    for (int i = 0; i < 3; i++) begin
      drive_upd0(1'b1, 9'd7, 1'b0, i == 2);
      tick();
    end
    drive_upd0(1'b0, '0, 1'b0, 1'b0);
    repeat (6) tick();

    // Speculative history 1,1,0 then restore racing a spec shift.
    sb_push("ghr_1",   K_GHR0, 8'h01, 1);
    sb_push("ghr_11",  K_GHR0, 8'h03, 2);
    sb_push("ghr_110", K_GHR0, 8'h06, 3);
    sb_push("idx_ghr6", K_IDX0, 7 ^ 6, 3);
    for (int i = 0; i < 3; i++) begin
      spec_v0 = 1'b1; spec_t0 = (i < 2);
      tick();
    end
    spec_v0 = 1'b1; spec_t0 = 1'b1;
    rest_v0 = 1'b1; rest_ghr0 = 8'h0F; rest_t0 = 1'b0;
    tick();
    spec_v0 = 1'b0; rest_v0 = 1'b0;
    sb_push("ghr_restore", K_GHR0, 8'h1E, 0);
    sb_push("idx_restore", K_IDX0, 7 ^ 8'h1E, 0);
    tick();

    // Debug mode drops updates to the predicted row but still shifts the GHR.
    debug0 = 1'b1;
    for (int d = 3; d <= 6; d++) begin
      sb_push("dbg_pv", K_PV0, 2'b00, d);
      sb_push("dbg_pt", K_PT0, 2'b11, d);
    end
    sb_push("dbg_ghr_hold", K_GHR0, 8'h1E, 3);
    for (int i = 0; i < 3; i++) begin
      drive_upd0(1'b1, 9'h19, 1'b0, 1'b0);
      tick();
    end
    drive_upd0(1'b0, '0, 1'b0, 1'b0);
    spec_v0 = 1'b1; spec_t0 = 1'b1;
    tick();
    spec_v0 = 1'b0;
    sb_push("dbg_ghr_shift", K_GHR0, 8'h3D, 0);
    sb_push("dbg_idx", K_IDX0, 7 ^ 8'h3D, 0);
    repeat (4) tick();
    debug0 = 1'b0;

    // Accepted update followed by a flush: sweep restores defaults, ready low throughout.
    c = cyc;
    sb_push("fl_pv_pre",   K_PV0,    2'b00, 1);
    sb_push("fl_busy_pre", K_BUSY0,  0, 1);
    sb_push("fl_busy",     K_BUSY0,  1, 2);
    sb_push("fl_ready",    K_READY0, 0, 2);
    sb_push("fl_ghr",      K_GHR0,   0, 2);
    sb_push("fl_pv_init",  K_PV0,    0, 2);
    sb_push("fl_pt_init",  K_PT0,    0, 2);
    sb_push("fl_pt_mid",   K_PT0,    0, 200);
    sb_push("fl_ready_mid", K_READY0, 0, 300);
    sb_push("fl_ready_end", K_READY0, 0, 513);
    sb_push("fl_busy_end", K_BUSY0,  1, 513);
    sb_push("fl_done",     K_BUSY0,  0, 514);
    sb_push("fl_done_rdy", K_READY0, 1, 514);
    sb_push("fl_idx_after", K_IDX0,  7, 515);
    sb_push("fl_ghr_after", K_GHR0,  0, 515);
    sb_push("fl_pv_after",  K_PV0,   2'b00, 515);
    sb_push("fl_pt_after",  K_PT0,   2'b11, 515);
    sb_push("fl_pv_late",   K_PV0,   2'b00, 520);
    sb_push("fl_pt_late",   K_PT0,   2'b11, 520);
    drive_upd0(1'b1, 9'h03A, 1'b1, 1'b0);
    tick();
    drive_upd0(1'b0, '0, 1'b0, 1'b0);
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    while (cyc < c + 510) tick();
    for (int i = 0; i < 4; i++) begin
      drive_upd0(1'b1, 9'd7, 1'b0, 1'b0);
      tick();
    end
    drive_upd0(1'b0, '0, 1'b0, 1'b0);
    while (cyc < c + 521) tick();
    vpc0 = 39'h0E8;
    sb_push("fl_dropped_idx", K_IDX0, 9'h03A, 0);
    sb_push("fl_dropped_pv",  K_PV0,  2'b00, 0);
    sb_push("fl_dropped_pt",  K_PT0,  2'b11, 0);
    repeat (3) tick();

    foreach (sb_q[i]) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s: expectation due at cyc %0d never compared", sb_q[i].tag, sb_q[i].due);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
